// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared state type and bus widths for the Wishbone arbiter
package wb_arb_pkg;
  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = 4;
  typedef enum logic [1:0] {IDLE, OWNED, ABORT} arb_state_e;
endpackage

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: one-hot pick of the first requester after the last owner, wrapping
module wb_rr_arbiter #(
  parameter int N_MASTERS = 2
) (
  input  logic [N_MASTERS-1:0]         req,
  input  logic [$clog2(N_MASTERS)-1:0] last,
  output logic [N_MASTERS-1:0]         gnt
);
  // Scan farthest-to-nearest so the nearest requester after last wins
  always_comb begin
    gnt = '0;
    for (int i = N_MASTERS; i >= 1; i--)
      if (req[(int'(last) + i) % N_MASTERS]) gnt = N_MASTERS'(1) << ((int'(last) + i) % N_MASTERS);
  end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin N:1 Wishbone arbiter with slave-response watchdog
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int TIMEOUT   = 255
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic [N_MASTERS-1:0]           m_cyc_i,
  input  logic [N_MASTERS-1:0]           m_stb_i,
  input  logic [N_MASTERS-1:0]           m_we_i,
  input  logic [WB_ADDR_W*N_MASTERS-1:0] m_adr_i,
  input  logic [WB_DATA_W*N_MASTERS-1:0] m_dat_i,
  input  logic [WB_SEL_W*N_MASTERS-1:0]  m_sel_i,
  output logic [WB_DATA_W-1:0]           m_dat_o,
  output logic [N_MASTERS-1:0]           m_ack_o,
  output logic [N_MASTERS-1:0]           m_err_o,
  output logic [N_MASTERS-1:0]           m_rty_o,
  output logic                           s_cyc_o,
  output logic                           s_stb_o,
  output logic                           s_we_o,
  output logic [WB_ADDR_W-1:0]           s_adr_o,
  output logic [WB_DATA_W-1:0]           s_dat_o,
  output logic [WB_SEL_W-1:0]            s_sel_o,
  input  logic [WB_DATA_W-1:0]           s_dat_i,
  input  logic                           s_ack_i,
  input  logic                           s_err_i,
  input  logic                           s_rty_i,
  output logic [N_MASTERS-1:0]           gnt_o,
  output logic                           timeout_o
);
  localparam int IW = $clog2(N_MASTERS);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  arb_state_e state, state_nx;
  logic [IW-1:0] owner, owner_nx, last, last_nx, rr_idx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [N_MASTERS-1:0] rr_gnt, own_oh;
  logic [1:0] rst_sync;
  logic rst_n, owned, own_cyc, term, stall, hit;
  // Reset asserts asynchronously but releases two clocks after rst_n_i rises
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) rst_sync <= '0;
    else rst_sync <= {rst_sync[0], 1'b1};
  assign rst_n = rst_sync[1];
  wb_rr_arbiter #(.N_MASTERS(N_MASTERS)) u_rr (
    .req (m_cyc_i),
    .last(last),
    .gnt (rr_gnt)
  );
  always_comb begin
    rr_idx = '0;
    for (int i = 0; i < N_MASTERS; i++) if (rr_gnt[i]) rr_idx = IW'(i);
  end
  assign own_oh  = N_MASTERS'(1) << owner;
  assign owned   = state == OWNED;
  assign own_cyc = m_cyc_i[owner];
  assign s_cyc_o = owned & own_cyc;
  assign s_stb_o = s_cyc_o & m_stb_i[owner];
  assign s_we_o  = s_cyc_o & m_we_i[owner];
  assign s_adr_o = m_adr_i[WB_ADDR_W*owner +: WB_ADDR_W];
  assign s_dat_o = m_dat_i[WB_DATA_W*owner +: WB_DATA_W];
  assign s_sel_o = m_sel_i[WB_SEL_W*owner +: WB_SEL_W];
  assign m_dat_o = s_dat_i;
  assign term    = s_ack_i | s_err_i | s_rty_i;
  assign stall   = s_stb_o & ~term;
  // A real termination on the limit cycle clears stall, so the slave wins
  assign hit       = TIMEOUT != 0 && stall && int'(cnt) == TIMEOUT - 1;
  assign timeout_o = hit;
  assign m_ack_o   = (s_cyc_o & s_ack_i) ? own_oh : '0;
  assign m_err_o   = ((s_cyc_o & s_err_i) | hit) ? own_oh : '0;
  assign m_rty_o   = (s_cyc_o & s_rty_i) ? own_oh : '0;
  assign gnt_o     = state == IDLE ? '0 : own_oh;
  assign cnt_nx    = stall && !hit ? (cnt == '1 ? cnt : cnt + 1'b1) : '0;
  always_comb begin
    state_nx = state;
    owner_nx = owner;
    last_nx  = last;
    case (state)
      IDLE: if (|m_cyc_i) begin
        state_nx = OWNED;
        owner_nx = rr_idx;
      end
      OWNED: if (!own_cyc) begin
        state_nx = IDLE;
        last_nx  = owner;
      end else if (hit) state_nx = ABORT;
      default: if (!own_cyc) begin
        state_nx = IDLE;
        last_nx  = owner;
      end
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      owner <= '0;
      last  <= IW'(N_MASTERS - 1);
      cnt   <= '0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      last  <= last_nx;
      cnt   <= cnt_nx;
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed and randomized checks of wb_arbiter against a transaction-level model
module tb_wb_arbiter;
  localparam int N  = 3;
  localparam int TO = 8;
  logic clk_i = 0, rst_n_i = 1;
  logic [N-1:0] m_cyc_i, m_stb_i, m_we_i;
  logic [32*N-1:0] m_adr_i, m_dat_i;
  logic [4*N-1:0] m_sel_i;
  logic [31:0] m_dat_o, s_adr_o, s_dat_o, s_dat_i;
  logic [N-1:0] m_ack_o, m_err_o, m_rty_o, gnt_o;
  logic s_cyc_o, s_stb_o, s_we_o, s_ack_i, s_err_i, s_rty_i, timeout_o;
  logic [3:0] s_sel_o;
  logic [31:0] adr [N], dat [N];
  logic [3:0] sel [N];
  logic we [N];
  int pass = 0, fails = 0, total = 0, last = N - 1, n;

  wb_arbiter #(.N_MASTERS(N), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .gnt_o(gnt_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL sim_timeout: observed no summary, expected finish");
    $fatal(1);
  end

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) pass++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic req(int m, logic [31:0] a, logic [31:0] d, logic [3:0] s, logic w);
    adr[m] = a; dat[m] = d; sel[m] = s; we[m] = w;
    m_cyc_i[m] = 1; m_stb_i[m] = 1; m_we_i[m] = w;
    m_adr_i[32*m +: 32] = a; m_dat_i[32*m +: 32] = d; m_sel_i[4*m +: 4] = s;
  endtask

  task automatic rreq(int m);
    req(m, $urandom, $urandom, 4'($urandom), 1'($urandom));
  endtask

  task automatic drop(int m);
    m_cyc_i[m] = 0;
    m_stb_i[m] = 0;
  endtask

  // Called in an idle cycle with master m already requesting; ends in the next idle cycle
  task automatic serve(int m, int lat, int kind);
    logic [N-1:0] oh;
    logic [31:0] rd;
    oh = N'(1) << m;
    #1;
    chk("idle_gnt", gnt_o, 0);
    chk("idle_cyc", s_cyc_o, 0);
    for (int i = 0; i <= lat; i++) begin
      tick();
      rd = $urandom;
      s_dat_i = rd;
      s_ack_i = i == lat && kind == 0;
      s_err_i = i == lat && kind == 1;
      s_rty_i = i == lat && kind == 2;
      #1;
      chk("gnt", gnt_o, oh);
      chk("s_cyc", s_cyc_o, 1);
      chk("s_stb", s_stb_o, 1);
      chk("s_we", s_we_o, we[m]);
      chk("s_adr", s_adr_o, adr[m]);
      chk("s_dat", s_dat_o, dat[m]);
      chk("s_sel", s_sel_o, sel[m]);
      chk("m_dat", m_dat_o, rd);
      chk("m_ack", m_ack_o, (i == lat && kind == 0) ? oh : N'(0));
      chk("m_err", m_err_o, (i == lat && kind == 1) ? oh : N'(0));
      chk("m_rty", m_rty_o, (i == lat && kind == 2) ? oh : N'(0));
      chk("timeout", timeout_o, 0);
    end
    tick();
    {s_ack_i, s_err_i, s_rty_i} = '0;
    drop(m);
    #1;
    chk("drop_cyc", s_cyc_o, 0);
    chk("drop_gnt", gnt_o, oh);
    last = m;
    tick();
  endtask

  // Masters in mask request together and hold until served: service order is round-robin from last
  task automatic round(logic [N-1:0] mask);
    int order[$];
    for (int j = 1; j <= N; j++) if (mask[(last + j) % N]) order.push_back((last + j) % N);
    for (int j = 0; j < N; j++) if (mask[j]) rreq(j);
    foreach (order[k]) serve(order[k], $urandom_range(4, 0), $urandom_range(2, 0));
  endtask

  initial begin
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
    s_dat_i = '0; s_ack_i = 0; s_err_i = 0; s_rty_i = 0;
    #1 rst_n_i = 0;
    #1;
    chk("rst_gnt", gnt_o, 0);
    chk("rst_cyc", s_cyc_o, 0);
    chk("rst_stb", s_stb_o, 0);
    chk("rst_ack", m_ack_o, 0);
    chk("rst_err", m_err_o, 0);
    chk("rst_timeout", timeout_o, 0);
    repeat (2) @(posedge clk_i);
    #2 rst_n_i = 1;
    repeat (3) tick();
    // Two masters re-requesting every cycle alternate 0,1,0,1
    rreq(0); rreq(1);
    serve(0, 0, 0);
    rreq(0);
    serve(1, 1, 0);
    rreq(1);
    serve(0, 0, 0);
    serve(1, 2, 0);
    // Single write from master 0 acked after two stalled cycles
    req(0, 32'h100, 32'hDEADBEEF, 4'hF, 1);
    serve(0, 2, 0);
    // Master 1 block transfer holds the grant while master 0 waits
    rreq(1);
    #1;
    chk("blk_idle", gnt_o, 0);
    tick();
    rreq(0);
    for (int b = 0; b < 4; b++) begin
      s_ack_i = 1;
      #1;
      chk("blk_gnt", gnt_o, N'(2));
      chk("blk_ack", m_ack_o, N'(2));
      chk("blk_adr", s_adr_o, adr[1]);
      tick();
    end
    s_ack_i = 0;
    drop(1);
    #1;
    chk("blk_rel_gnt", gnt_o, N'(2));
    last = 1;
    tick();
    serve(0, 1, 0);
    // Silent slave: error and pulse on the 8th stalled cycle, then abort
    rreq(0);
    #1;
    chk("to_idle", gnt_o, 0);
    for (int i = 1; i <= TO; i++) begin
      tick();
      #1;
      chk("to_cyc", s_cyc_o, 1);
      chk("to_err", m_err_o, i == TO ? N'(1) : N'(0));
      chk("to_pulse", timeout_o, i == TO);
    end
    tick();
    #1;
    chk("abort_cyc", s_cyc_o, 0);
    chk("abort_stb", s_stb_o, 0);
    chk("abort_err", m_err_o, 0);
    chk("abort_pulse", timeout_o, 0);
    chk("abort_gnt", gnt_o, N'(1));
    tick();
    #1;
    chk("abort_hold_gnt", gnt_o, N'(1));
    chk("abort_hold_cyc", s_cyc_o, 0);
    drop(0);
    tick();
    #1;
    chk("abort_exit", gnt_o, 0);
    last = 0;
    // Ack on the limit cycle wins over the watchdog
    rreq(0);
    for (int i = 1; i <= TO; i++) begin
      tick();
      s_ack_i = i == TO;
      #1;
      chk("lim_ack", m_ack_o, i == TO ? N'(1) : N'(0));
      chk("lim_noerr", m_err_o, 0);
      chk("lim_nopulse", timeout_o, 0);
    end
    tick();
    s_ack_i = 0;
    #1;
    chk("lim_owned", s_cyc_o, 1);
    chk("lim_gnt", gnt_o, N'(1));
    drop(0);
    #1;
    chk("lim_drop_cyc", s_cyc_o, 0);
    last = 0;
    tick();
    for (int r = 0; r < 12; r++) round(N'($urandom_range(7, 1)));
    // Reset mid-transfer clears everything at once; master 0 is served first afterwards
    rreq(1);
    #1;
    tick();
    #1;
    chk("pre_rst_gnt", gnt_o, N'(2));
    s_ack_i = 1;
    rst_n_i = 0;
    #1;
    chk("arst_gnt", gnt_o, 0);
    chk("arst_cyc", s_cyc_o, 0);
    chk("arst_stb", s_stb_o, 0);
    chk("arst_ack", m_ack_o, 0);
    chk("arst_err", m_err_o, 0);
    s_ack_i = 0;
    rreq(0);
    tick();
    tick();
    #1;
    chk("in_rst_gnt", gnt_o, 0);
    rst_n_i = 1;
    n = 0;
    while (gnt_o == 0 && n < 8) begin
      tick();
      #1;
      n++;
    end
    chk("post_rst_gnt", gnt_o, N'(1));
    drop(0);
    drop(1);
    tick();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
